// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
//   dm_state_e : arbiter FSM states (IDLE, RD_WAIT)
//   PORT_C/D   : port identifiers used for owner and last-winner tracking
//   WEA_*      : byte-lane write-enable constants
//   dm_req_t   : request payload carried alongside a master's req
package dm_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LANE_W = 4;
    localparam int unsigned LAT_W  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } dm_state_e;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [LANE_W-1:0] WEA_NONE = 4'b0000;
    localparam logic [LANE_W-1:0] WEA_WORD = 4'b1111;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LANE_W-1:0] wea;
        logic [DATA_W-1:0] wdata;
    } dm_req_t;

    // Reads never touch the BRAM byte enables.
    function automatic logic [LANE_W-1:0] lane_mask(input logic we, input logic [LANE_W-1:0] wea);
        return we ? wea : WEA_NONE;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// One master's view of the shared data-memory port.
//   req    : request, held until gnt
//   cmd    : we / byte address / lane enables / write data
//   gnt    : request accepted this cycle (combinational from the arbiter)
//   rvalid : one-cycle read-data-valid pulse
//   rdata  : raw read word, held until the next read by this master
interface dm_port_arbiter_if;
    import dm_pkg::*;

    logic              req;
    dm_req_t           cmd;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, cmd, input  gnt, rvalid, rdata);
    modport slave  (input  req, cmd, output gnt, rvalid, rdata);

endinterface

// File: rtl/dm_port_arbiter_pick.sv
// Combinational two-way winner select.
//   c_req, d_req : requests already qualified by the arbiter being free
//   last_win     : previous winner, used only in round-robin mode
//   starve       : D has waited too long, used only in fixed-priority mode
//   win_valid_c  : some port wins this cycle
//   win_port_c   : winning port id (PORT_C / PORT_D)
module dm_arb_pick
    import dm_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic c_req,
    input  logic d_req,
    input  logic last_win,
    input  logic starve,
    output logic win_valid_c,
    output logic win_port_c
);

    // Contention is the only case needing policy; a lone requester always wins.
    always_comb begin
        win_valid_c = c_req | d_req;
        win_port_c  = PORT_C;
        if (c_req && d_req) begin
            if (RR_EN) begin
                win_port_c = ~last_win;
            end else if (starve) begin
                win_port_c = PORT_D;
            end
        end else if (d_req) begin
            win_port_c = PORT_D;
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single data-memory BRAM port between the core (C) and DMA/debug (D).
// Build option: DM_ARB_RR_EN selects two-way round-robin; undefined gives fixed
// priority (C over D) with a starvation counter that force-grants D.
//   clk, rstn        : clock, asynchronous active-low reset
//   c_port, d_port   : master ports (req/cmd in, gnt/rvalid/rdata out)
//   dm_addr          : BRAM word address (byte address bits AW+1:2)
//   dm_wea, dm_din   : BRAM byte write enables and write data
//   dm_dout          : BRAM read data, valid RD_LAT cycles after the address
//   busy             : a read is outstanding
module dm_port_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned AW         = 12,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned D_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rstn,
    dm_port_arbiter_if.slave  c_port,
    dm_port_arbiter_if.slave  d_port,
    output logic [AW-1:0]     dm_addr,
    output logic [LANE_W-1:0] dm_wea,
    output logic [DATA_W-1:0] dm_din,
    input  logic [DATA_W-1:0] dm_dout,
    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("dm_port_arbiter: RD_LAT must be 1..4");
    end
    if (D_MAX_WAIT < 1) begin : g_bad_max_wait
        $error("dm_port_arbiter: D_MAX_WAIT must be at least 1");
    end

    dm_state_e         state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              owner_q, owner_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              last_win_q, last_win_d;
    logic              c_rvalid_q, c_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              arb_en;
    logic              win_valid_c;
    logic              win_port_c;
    logic              starve;
    logic              c_gnt_c, d_gnt_c;
    dm_req_t           win_cmd;
    logic [AW-1:0]     dm_addr_c;
    logic [LANE_W-1:0] dm_wea_c;
    logic [DATA_W-1:0] dm_din_c;

    // Gating with rstn keeps every grant and write enable low while in reset.
    assign arb_en = rstn && (state_q == IDLE);

`ifdef DM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;

    assign starve = 1'b0;
`else
    localparam bit RR_EN = 1'b0;
    localparam int unsigned WAIT_W = $clog2(D_MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_q;

    // Consecutive denied D cycles, saturating at the force-grant threshold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_q <= '0;
        end else if (!d_port.req || d_gnt_c) begin
            wait_q <= '0;
        end else if (wait_q != WAIT_W'(D_MAX_WAIT)) begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end

    assign starve = (wait_q == WAIT_W'(D_MAX_WAIT));
`endif

    dm_arb_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .c_req       (c_port.req & arb_en),
        .d_req       (d_port.req & arb_en),
        .last_win    (last_win_q),
        .starve      (starve),
        .win_valid_c (win_valid_c),
        .win_port_c  (win_port_c)
    );

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            owner_q    <= PORT_C;
            addr_q     <= '0;
            last_win_q <= PORT_D;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            last_win_q <= last_win_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next state, grants and BRAM port mux.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        last_win_d = last_win_q;
        c_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        c_rdata_d  = c_rdata_q;
        d_rdata_d  = d_rdata_q;
        c_gnt_c    = 1'b0;
        d_gnt_c    = 1'b0;
        win_cmd    = (win_port_c == PORT_D) ? d_port.cmd : c_port.cmd;
        dm_addr_c  = addr_q;
        dm_wea_c   = WEA_NONE;
        dm_din_c   = win_cmd.wdata;

        unique case (state_q)
            IDLE: begin
                if (win_valid_c) begin
                    c_gnt_c    = (win_port_c == PORT_C);
                    d_gnt_c    = (win_port_c == PORT_D);
                    dm_addr_c  = win_cmd.addr[AW+1:2];
                    dm_wea_c   = lane_mask(win_cmd.we, win_cmd.wea);
                    addr_d     = win_cmd.addr[AW+1:2];
                    last_win_d = win_port_c;
                    // Writes retire in the grant cycle; reads park the port.
                    if (!win_cmd.we) begin
                        state_d = RD_WAIT;
                        lat_d   = LAT_W'(RD_LAT);
                        owner_d = win_port_c;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_q != '0) begin
                    lat_d = lat_q - LAT_W'(1);
                    // dm_dout is valid now; it lands in rdata as lat_cnt hits 0.
                    if (lat_q == LAT_W'(1)) begin
                        if (owner_q == PORT_C) begin
                            c_rdata_d  = dm_dout;
                            c_rvalid_d = 1'b1;
                        end else begin
                            d_rdata_d  = dm_dout;
                            d_rvalid_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign c_port.gnt    = c_gnt_c;
    assign d_port.gnt    = d_gnt_c;
    assign c_port.rvalid = c_rvalid_q;
    assign d_port.rvalid = d_rvalid_q;
    assign c_port.rdata  = c_rdata_q;
    assign d_port.rdata  = d_rdata_q;
    assign dm_addr       = dm_addr_c;
    assign dm_wea        = dm_wea_c;
    assign dm_din        = dm_din_c;
    assign busy          = (state_q == RD_WAIT);

    // Byte-offset and out-of-range address bits do not reach the BRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{c_port.cmd.addr[ADDR_W-1:AW+2], c_port.cmd.addr[1:0],
                                d_port.cmd.addr[ADDR_W-1:AW+2], d_port.cmd.addr[1:0]};

    a_one_gnt: assert property (@(posedge clk) disable iff (!rstn)
        !(c_gnt_c && d_gnt_c));

    a_c_hold: assert property (@(posedge clk) disable iff (!rstn)
        (c_port.req && !c_gnt_c) |=> (!c_port.req ||
            (c_port.cmd.addr == $past(c_port.cmd.addr) && c_port.cmd.we == $past(c_port.cmd.we))));

    a_d_hold: assert property (@(posedge clk) disable iff (!rstn)
        (d_port.req && !d_gnt_c) |=> (!d_port.req ||
            (d_port.cmd.addr == $past(d_port.cmd.addr) && d_port.cmd.we == $past(d_port.cmd.we))));

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;
    import dm_pkg::*;

    localparam int unsigned AW         = 12;
    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned D_MAX_WAIT = 8;

    logic              clk;
    logic              rstn;
    logic [AW-1:0]     dm_addr;
    logic [3:0]        dm_wea;
    logic [31:0]       dm_din;
    logic [31:0]       dm_dout;
    logic              busy;

    dm_port_arbiter_if c_if ();
    dm_port_arbiter_if d_if ();

    dm_port_arbiter #(
        .AW         (AW),
        .RD_LAT     (RD_LAT),
        .D_MAX_WAIT (D_MAX_WAIT)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .c_port  (c_if),
        .d_port  (d_if),
        .dm_addr (dm_addr),
        .dm_wea  (dm_wea),
        .dm_din  (dm_din),
        .dm_dout (dm_dout),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM with RD_LAT-cycle read pipeline.
    logic [31:0] bram [0:(1<<AW)-1];
    logic [31:0] pipe [RD_LAT];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (dm_wea[b]) bram[dm_addr][8*b +: 8] <= dm_din[8*b +: 8];
        pipe[0] <= bram[dm_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dm_dout = pipe[RD_LAT-1];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: transaction-level schedule of the shared port.
    int          cyc;
    int          free_at;     // first cycle a new grant may happen
    int          rv_at;       // cycle the pending read returns
    int          rv_port;
    logic [31:0] rv_data;
    logic [AW-1:0] rd_word;
    int          d_wait;
    int          last_w;
    logic [31:0] exp_rdata [2];
    logic [31:0] ref_mem [16];
    bit          won [2];

    bit          req_v [2];
    dm_req_t     cmd_v [2];

    task automatic model_reset();
        free_at = 0; rv_at = -1; rv_port = 0; d_wait = 0; last_w = 1;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        won[0] = 1'b0; won[1] = 1'b0;
    endtask

    task automatic check_cycle();
        int      win;
        dm_req_t wc;
        if (!rstn) begin
            check("rst_c_gnt", 32'(c_if.gnt), 0);
            check("rst_d_gnt", 32'(d_if.gnt), 0);
            check("rst_c_rvalid", 32'(c_if.rvalid), 0);
            check("rst_d_rvalid", 32'(d_if.rvalid), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_dm_wea", 32'(dm_wea), 0);
            check("rst_c_rdata", c_if.rdata, 0);
            check("rst_d_rdata", d_if.rdata, 0);
            model_reset();
            cyc++;
            return;
        end
        win = -1;
        if (cyc >= free_at) begin
            if (req_v[0] && req_v[1]) begin
`ifdef DM_ARB_RR_EN
                win = (last_w == 0) ? 1 : 0;
`else
                win = (d_wait >= int'(D_MAX_WAIT)) ? 1 : 0;
`endif
            end else if (req_v[0]) begin
                win = 0;
            end else if (req_v[1]) begin
                win = 1;
            end
        end
        won[0] = (win == 0);
        won[1] = (win == 1);
        if (cyc == rv_at) exp_rdata[rv_port] = rv_data;

        check("c_gnt", 32'(c_if.gnt), 32'(won[0]));
        check("d_gnt", 32'(d_if.gnt), 32'(won[1]));
        check("busy", 32'(busy), 32'(cyc < free_at));
        check("c_rvalid", 32'(c_if.rvalid), 32'(cyc == rv_at && rv_port == 0));
        check("d_rvalid", 32'(d_if.rvalid), 32'(cyc == rv_at && rv_port == 1));
        check("c_rdata", c_if.rdata, exp_rdata[0]);
        check("d_rdata", d_if.rdata, exp_rdata[1]);

        if (win >= 0) begin
            wc = cmd_v[win];
            check("dm_addr", 32'(dm_addr), 32'(wc.addr[AW+1:2]));
            check("dm_wea", 32'(dm_wea), wc.we ? 32'(wc.wea) : 32'd0);
            if (wc.we) begin
                check("dm_din", dm_din, wc.wdata);
                for (int b = 0; b < 4; b++)
                    if (wc.wea[b]) ref_mem[wc.addr[5:2]][8*b +: 8] = wc.wdata[8*b +: 8];
            end else begin
                rd_word = wc.addr[AW+1:2];
                rv_at   = cyc + int'(RD_LAT) + 1;
                free_at = cyc + int'(RD_LAT) + 2;
                rv_port = win;
                rv_data = ref_mem[wc.addr[5:2]];
            end
            last_w = win;
        end else if (cyc < free_at) begin
            check("rd_hold_addr", 32'(dm_addr), 32'(rd_word));
            check("rd_wea", 32'(dm_wea), 0);
        end else begin
            check("idle_wea", 32'(dm_wea), 0);
        end

        if (req_v[1] && win != 1)
            d_wait = (d_wait < int'(D_MAX_WAIT)) ? d_wait + 1 : d_wait;
        else
            d_wait = 0;
        cyc++;
    endtask

    function automatic dm_req_t rand_cmd(input int wr_pct);
        dm_req_t c;
        c.we    = ($urandom_range(0, 99) < wr_pct);
        c.addr  = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
        c.wea   = 4'($urandom);
        c.wdata = $urandom;
        return c;
    endfunction

    function automatic dm_req_t mk_cmd(input logic we, input logic [31:0] addr,
                                       input logic [3:0] wea, input logic [31:0] wdata);
        dm_req_t c;
        c.we = we; c.addr = addr; c.wea = wea; c.wdata = wdata;
        return c;
    endfunction

    task automatic drive();
        c_if.req = req_v[0]; c_if.cmd = cmd_v[0];
        d_if.req = req_v[1]; d_if.cmd = cmd_v[1];
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    // mode 0: granted requests retire; 1: granted port re-requests a new write;
    // 2: random masters with legal drops.
    task automatic cycles(input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (mode == 1) begin
                    if (won[p]) cmd_v[p] = rand_cmd(100);
                end else if (won[p]) begin
                    req_v[p] = 1'b0;
                    if (mode == 2 && $urandom_range(0, 99) < 50) begin
                        req_v[p] = 1'b1;
                        cmd_v[p] = rand_cmd(50);
                    end
                end else if (mode == 2) begin
                    if (req_v[p]) begin
                        if ($urandom_range(0, 15) == 0) req_v[p] = 1'b0;
                    end else if ($urandom_range(0, 99) < 50) begin
                        req_v[p] = 1'b1;
                        cmd_v[p] = rand_cmd(50);
                    end
                end
            end
            drive();
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        cmd_v[0] = '0;   cmd_v[1] = '0;
        drive();
        rstn = 1'b0;
        cycles(3, 0);
        rstn = 1'b1;

        // Fill the 16 words the bench addresses.
        for (int w = 0; w < 16; w++) begin
            req_v[0] = 1'b1;
            cmd_v[0] = mk_cmd(1'b1, 32'(w) << 2, WEA_WORD, $urandom);
            drive();
            cycles(1, 0);
        end

        // Core write then read of 0x10.
        req_v[0] = 1'b1;
        cmd_v[0] = mk_cmd(1'b1, 32'h10, WEA_WORD, 32'hDEAD_BEEF);
        drive();
        cycles(1, 0);
        req_v[0] = 1'b1;
        cmd_v[0] = mk_cmd(1'b0, 32'h10, WEA_NONE, 32'h0);
        drive();
        cycles(RD_LAT + 3, 0);

        // Both masters hammering writes after a fresh reset.
        rstn = 1'b0;
        cycles(1, 0);
        rstn = 1'b1;
        req_v[0] = 1'b1; cmd_v[0] = rand_cmd(100);
        req_v[1] = 1'b1; cmd_v[1] = rand_cmd(100);
        drive();
        cycles(24, 1);
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        drive();
        cycles(2, 0);

        // D read arrives while a C read is outstanding.
        req_v[0] = 1'b1;
        cmd_v[0] = mk_cmd(1'b0, 32'h10, WEA_NONE, 32'h0);
        drive();
        cycles(1, 0);
        req_v[1] = 1'b1;
        cmd_v[1] = mk_cmd(1'b0, 32'h24, WEA_NONE, 32'h0);
        drive();
        cycles(RD_LAT + 6, 0);

        // Reset in the middle of a read, then normal service.
        req_v[0] = 1'b1;
        cmd_v[0] = mk_cmd(1'b0, 32'h8, WEA_NONE, 32'h0);
        drive();
        cycles(2, 0);
        rstn = 1'b0;
        cycles(2, 0);
        rstn = 1'b1;
        cycles(4, 0);
        req_v[0] = 1'b1;
        cmd_v[0] = mk_cmd(1'b0, 32'h8, WEA_NONE, 32'h0);
        drive();
        cycles(RD_LAT + 3, 0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                rstn = 1'b0;
                cycles(2, 0);
                rstn = 1'b1;
            end
            cycles(1, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
